// File: rtl/microbench_pkg.sv
// Shared definitions for the microbenchmark memory sequencer.
// Holds opcode values, the sequencer state encoding, the error response
// word and the width of the cycle/mismatch counters.
package microbench_pkg;

  // Width of the cycle and mismatch counters reported to the thread
  localparam int unsigned CNT_W = 32;

  // Opcode field (top two bits of the command word)
  localparam logic [1:0] OP_FILL   = 2'b01;
  localparam logic [1:0] OP_VERIFY = 2'b10;

  // Response for an illegal opcode; truncated to the channel width on use
  localparam logic [63:0] RESP_ERR = 64'hFFFF_FFFF_FFFF_FFFF;

  // Sequencer state encoding
  localparam int unsigned ST_W = 4;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 4'd0,
    ST_CWAIT = 4'd1,
    ST_ARG   = 4'd2,
    ST_AWAIT = 4'd3,
    ST_RUN   = 4'd4,
    ST_DRAIN = 4'd5,
    ST_RESP0 = 4'd6,
    ST_RESP1 = 4'd7,
    ST_ERR   = 4'd8
  } state_e;

endpackage

// File: rtl/microbench_seq_ctrl_if.sv
// Channel and memory-port bundle of the microbenchmark sequencer.
//   comm_q/comm_empty/comm_deq : command channel head, empty flag, pop pulse
//   comm_d/comm_enq/comm_full  : response word, push pulse, full flag
//   mem_addr/mem_d/mem_we/mem_q: single-port memory, 1-cycle read latency
//   busy                       : sequencer not idle
// master = sequencer side, slave = channel/memory side.
interface microbench_seq_ctrl_if #(
  parameter int unsigned SIMD_WIDTH = 1,
  parameter int unsigned W_D        = 32,
  parameter int unsigned W_A        = 12,
  parameter int unsigned W_COMM_D   = 32
) ();

  logic [W_COMM_D-1:0]       comm_q;
  logic                      comm_empty;
  logic                      comm_deq;
  logic [W_COMM_D-1:0]       comm_d;
  logic                      comm_enq;
  logic                      comm_full;
  logic [W_A-1:0]            mem_addr;
  logic [W_D*SIMD_WIDTH-1:0] mem_d;
  logic                      mem_we;
  logic [W_D*SIMD_WIDTH-1:0] mem_q;
  logic                      busy;

  modport master (
    input  comm_q, comm_empty, comm_full, mem_q,
    output comm_deq, comm_d, comm_enq, mem_addr, mem_d, mem_we, busy
  );

  modport slave (
    output comm_q, comm_empty, comm_full, mem_q,
    input  comm_deq, comm_d, comm_enq, mem_addr, mem_d, mem_we, busy
  );

endinterface

// File: rtl/microbench_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear to zero (wins over inc)
//   inc      : add one unless already all-ones
//   count    : current value
module microbench_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/microbench_seq_ctrl.sv
// Command-driven fill/verify sequencer for one single-port memory.
// Pops a command word and a seed word from the channel, writes or checks
// LEN words of the pattern (SEED+i) replicated across lanes, then pushes
// the measured cycle count (and the mismatch count for verify).
//   CLK, RST : clock, synchronous active-high reset
//   bus      : channel + memory bundle (master side), all outputs registered
module microbench_seq_ctrl
  import microbench_pkg::*;
#(
  parameter int unsigned SIMD_WIDTH = 1,
  parameter int unsigned W_D        = 32,
  parameter int unsigned W_A        = 12,
  parameter int unsigned W_COMM_D   = 32
) (
  input logic                   CLK,
  input logic                   RST,
  microbench_seq_ctrl_if.master bus
);

  localparam int unsigned W_L = W_A + 1;
  localparam int unsigned W_M = W_D * SIMD_WIDTH;

  state_e              state_q, state_d;

  // Latched command fields
  logic [1:0]          op_q;
  logic [W_L-1:0]      len_q;
  logic [W_D-1:0]      seed_q;

  // Index currently presented on the memory port
  logic [W_L-1:0]      idx_q, idx_d;

  // Pending read compare, one cycle behind the issued index
  logic                cmp_v_q, cmp_v_d;
  logic [W_D-1:0]      cmp_pat_q, cmp_pat_d;

  // Registered outputs and their next values
  logic                deq_q, deq_d;
  logic                enq_q, enq_d;
  logic                we_q, we_d;
  logic                busy_q, busy_d;
  logic [W_COMM_D-1:0] resp_q, resp_d;
  logic [W_A-1:0]      addr_q, addr_d;
  logic [W_M-1:0]      wdata_q, wdata_d;

  logic                cmd_ld, arg_ld, cnt_clr, cyc_inc, mis_inc;
  logic [CNT_W-1:0]    cyc_cnt, mis_cnt;
  logic                is_fill, opcode_ok, last_idx;
  logic [W_D-1:0]      pat_next;

  assign is_fill   = (op_q == OP_FILL);
  assign opcode_ok = (op_q == OP_FILL) || (op_q == OP_VERIFY);
  assign last_idx  = (idx_q == len_q - W_L'(1));
  assign pat_next  = seed_q + W_D'(idx_q + W_L'(1));

  // Any differing lane in the returned word counts as one mismatch
  assign mis_inc = cmp_v_q && (bus.mem_q != {SIMD_WIDTH{cmp_pat_q}});

  microbench_sat_counter #(.W(CNT_W)) u_cyc_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clr   (cnt_clr),
    .inc   (cyc_inc),
    .count (cyc_cnt)
  );

  microbench_sat_counter #(.W(CNT_W)) u_mis_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clr   (cnt_clr),
    .inc   (mis_inc),
    .count (mis_cnt)
  );

  // Next state and next registered outputs
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cmp_v_d   = 1'b0;
    cmp_pat_d = cmp_pat_q;
    deq_d     = 1'b0;
    enq_d     = 1'b0;
    we_d      = 1'b0;
    resp_d    = resp_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cmd_ld    = 1'b0;
    arg_ld    = 1'b0;
    cnt_clr   = 1'b0;
    cyc_inc   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!bus.comm_empty) begin
          deq_d   = 1'b1;
          cmd_ld  = 1'b1;
          state_d = ST_CWAIT;
        end
      end

      // Empty flag still reflects the popped word this cycle
      ST_CWAIT: begin
        state_d = opcode_ok ? ST_ARG : ST_ERR;
      end

      ST_ARG: begin
        if (!bus.comm_empty) begin
          deq_d   = 1'b1;
          arg_ld  = 1'b1;
          cnt_clr = 1'b1;
          state_d = ST_AWAIT;
        end
      end

      // Present index 0 so it is on the port in the first RUN cycle
      ST_AWAIT: begin
        if (len_q == '0) begin
          state_d = ST_RESP0;
        end else begin
          state_d = ST_RUN;
          idx_d   = '0;
          addr_d  = '0;
          wdata_d = {SIMD_WIDTH{seed_q}};
          we_d    = is_fill;
        end
      end

      ST_RUN: begin
        cyc_inc = 1'b1;
        addr_d  = addr_q + W_A'(1);
        if (!is_fill) begin
          cmp_v_d   = 1'b1;
          cmp_pat_d = seed_q + W_D'(idx_q);
        end
        if (last_idx) begin
          state_d = is_fill ? ST_RESP0 : ST_DRAIN;
        end else begin
          idx_d   = idx_q + W_L'(1);
          wdata_d = {SIMD_WIDTH{pat_next}};
          we_d    = is_fill;
        end
      end

      // Last read data arrives here
      ST_DRAIN: begin
        cyc_inc = 1'b1;
        state_d = ST_RESP0;
      end

      ST_RESP0: begin
        if (!bus.comm_full) begin
          enq_d   = 1'b1;
          resp_d  = W_COMM_D'(cyc_cnt);
          state_d = is_fill ? ST_IDLE : ST_RESP1;
        end
      end

      ST_RESP1: begin
        if (!bus.comm_full) begin
          enq_d   = 1'b1;
          resp_d  = W_COMM_D'(mis_cnt);
          state_d = ST_IDLE;
        end
      end

      ST_ERR: begin
        if (!bus.comm_full) begin
          enq_d   = 1'b1;
          resp_d  = W_COMM_D'(RESP_ERR);
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, command fields and compare pipeline
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      len_q     <= '0;
      seed_q    <= '0;
      idx_q     <= '0;
      cmp_v_q   <= 1'b0;
      cmp_pat_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cmp_v_q   <= cmp_v_d;
      cmp_pat_q <= cmp_pat_d;
      if (cmd_ld) begin
        op_q  <= bus.comm_q[W_COMM_D-1 -: 2];
        len_q <= bus.comm_q[W_A:0];
      end
      if (arg_ld) begin
        seed_q <= bus.comm_q[W_D-1:0];
      end
    end
  end

  // Output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      deq_q   <= 1'b0;
      enq_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      resp_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      deq_q   <= deq_d;
      enq_q   <= enq_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      resp_q  <= resp_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.comm_deq = deq_q;
  assign bus.comm_enq = enq_q;
  assign bus.comm_d   = resp_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_d    = wdata_q;
  assign bus.mem_we   = we_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_microbench_seq_ctrl.sv
// Bench for microbench_seq_ctrl: channel, response sink and RAM are modelled
// in the bench; a transaction-level model predicts writes and responses.
module tb_microbench_seq_ctrl;

  localparam int unsigned SIMD_WIDTH = 1;
  localparam int unsigned W_D        = 32;
  localparam int unsigned W_A        = 12;
  localparam int unsigned W_COMM_D   = 32;
  localparam int unsigned DEPTH      = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  microbench_seq_ctrl_if #(
    .SIMD_WIDTH(SIMD_WIDTH), .W_D(W_D), .W_A(W_A), .W_COMM_D(W_COMM_D)
  ) bus ();

  microbench_seq_ctrl #(
    .SIMD_WIDTH(SIMD_WIDTH), .W_D(W_D), .W_A(W_A), .W_COMM_D(W_COMM_D)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;

  logic [31:0] chq[$];
  logic [31:0] exp_resp[$];
  logic [11:0] exp_wa[$];
  logic [31:0] exp_wd[$];
  logic [31:0] got_resp[$];
  logic [31:0] ram [DEPTH];
  int          wcount [DEPTH];

  int enq_cnt = 0;
  int deq_cnt = 0;
  int wr_total = 0;

  logic        s_deq, s_enq, s_we, s_busy;
  logic [31:0] s_d, s_md;
  logic [11:0] s_addr;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic refresh_chan();
    bus.comm_empty = (chq.size() == 0);
    bus.comm_q     = (chq.size() == 0) ? 32'h0 : chq[0];
  endtask

  // Predict the writes and responses of one command from the spec rules
  task automatic model(input logic [1:0] op, input int len, input logic [31:0] seed);
    int mism;
    if (op == 2'b01) begin
      for (int i = 0; i < len; i++) begin
        exp_wa.push_back(12'(i % DEPTH));
        exp_wd.push_back(seed + 32'(i));
      end
      exp_resp.push_back(32'(len));
    end else if (op == 2'b10) begin
      mism = 0;
      for (int i = 0; i < len; i++)
        if (ram[i % DEPTH] != seed + 32'(i)) mism++;
      exp_resp.push_back(len == 0 ? 32'h0 : 32'(len + 1));
      exp_resp.push_back(32'(mism));
    end else begin
      exp_resp.push_back(32'hFFFF_FFFF);
    end
  endtask

  function automatic logic [31:0] cmd_word(input logic [1:0] op, input int len);
    return {op, 30'(len)};
  endfunction

  task automatic issue(input logic [1:0] op, input int len, input logic [31:0] seed);
    model(op, len, seed);
    chq.push_back(cmd_word(op, len));
    chq.push_back(seed);
    refresh_chan();
  endtask

  // One clock: compare outputs mid-cycle, then apply channel/RAM effects
  task automatic tick();
    @(negedge clk);
    s_deq  = bus.comm_deq;
    s_enq  = bus.comm_enq;
    s_we   = bus.mem_we;
    s_busy = bus.busy;
    s_d    = bus.comm_d;
    s_md   = bus.mem_d;
    s_addr = bus.mem_addr;
    if (s_enq) begin
      enq_cnt++;
      chk("enq_while_full", 64'(bus.comm_full), 64'h0);
      if (exp_resp.size() == 0) chk("resp_unexpected", 64'(exp_resp.size()), 64'h1);
      else chk("resp", 64'(s_d), 64'(exp_resp.pop_front()));
      got_resp.push_back(s_d);
    end
    if (s_deq) begin
      deq_cnt++;
      chk("deq_while_empty", 64'(bus.comm_empty), 64'h0);
    end
    if (s_we) begin
      wr_total++;
      wcount[s_addr]++;
      if (exp_wa.size() == 0) chk("write_unexpected", 64'(exp_wa.size()), 64'h1);
      else begin
        chk("wr_addr", 64'(s_addr), 64'(exp_wa.pop_front()));
        chk("wr_data", 64'(s_md), 64'(exp_wd.pop_front()));
      end
    end
    @(posedge clk);
    #1;
    if (s_deq && chq.size() > 0) chq.delete(0);
    bus.mem_q = ram[s_addr];
    if (s_we) ram[s_addr] = s_md;
    refresh_chan();
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((exp_resp.size() != 0 || s_busy) && n < budget);
    chk("done_in_budget", 64'(exp_resp.size()), 64'h0);
    chk("writes_all_seen", 64'(exp_wa.size()), 64'h0);
  endtask

  function automatic logic [31:0] last_resp(input int k);
    return got_resp[got_resp.size() - 1 - k];
  endfunction

  initial begin
    int e0, d0, w0, n, bad;
    bus.comm_full = 1'b0;
    bus.mem_q     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]    = 32'h0;
      wcount[i] = 0;
    end
    refresh_chan();

    // Reset values
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset_flags", {60'h0, s_deq, s_enq, s_we, s_busy}, 64'h0);
    chk("reset_comm_d", 64'(s_d), 64'h0);
    chk("reset_mem_addr", 64'(s_addr), 64'h0);
    chk("reset_mem_d", 64'(s_md), 64'h0);

    // FILL 16
    issue(2'b01, 16, 32'h100);
    wait_done(100);
    chk("fill16_resp", 64'(last_resp(0)), 64'd16);
    chk("fill16_ram0", 64'(ram[0]), 64'h100);
    chk("fill16_ram15", 64'(ram[15]), 64'h10F);

    // VERIFY clean
    issue(2'b10, 16, 32'h100);
    wait_done(100);
    chk("verify_cycles", 64'(last_resp(1)), 64'd17);
    chk("verify_mism", 64'(last_resp(0)), 64'd0);

    // VERIFY with two corrupted words
    ram[5]  = ram[5] ^ 32'h0000_0001;
    ram[15] = ram[15] ^ 32'h8000_0000;
    issue(2'b10, 16, 32'h100);
    wait_done(100);
    chk("verify_bad_cycles", 64'(last_resp(1)), 64'd17);
    chk("verify_bad_mism", 64'(last_resp(0)), 64'd2);

    // FILL LEN=0
    w0 = wr_total;
    issue(2'b01, 0, 32'h5);
    wait_done(100);
    chk("len0_resp", 64'(last_resp(0)), 64'd0);
    chk("len0_no_write", 64'(wr_total - w0), 64'd0);

    // Illegal opcode: argument word becomes the next command
    model(2'b11, 0, 32'h0);
    model(2'b01, 3, 32'h7);
    chq.push_back(cmd_word(2'b11, 16));
    chq.push_back(cmd_word(2'b01, 3));
    chq.push_back(32'h7);
    refresh_chan();
    wait_done(100);
    chk("err_resp", 64'(last_resp(1)), 64'hFFFF_FFFF);
    chk("err_next_resp", 64'(last_resp(0)), 64'd3);
    chk("err_ram2", 64'(ram[2]), 64'h9);

    // Full-depth FILL
    for (int i = 0; i < DEPTH; i++) wcount[i] = 0;
    issue(2'b01, 4096, 32'hA000_0000);
    wait_done(5000);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (wcount[i] != 1) bad++;
    chk("full_each_addr_once", 64'(bad), 64'd0);
    chk("full_resp", 64'(last_resp(0)), 64'd4096);
    chk("full_addr_wrapped", 64'(s_addr), 64'd0);
    chk("full_ram_top", 64'(ram[4095]), 64'hA000_0FFF);

    // Response stall while full
    bus.comm_full = 1'b1;
    e0 = enq_cnt;
    issue(2'b01, 4, 32'h20);
    for (int i = 0; i < 22; i++) tick();
    chk("stall_no_enq", 64'(enq_cnt - e0), 64'd0);
    chk("stall_busy", 64'(s_busy), 64'd1);
    bus.comm_full = 1'b0;
    wait_done(50);
    chk("stall_one_enq", 64'(enq_cnt - e0), 64'd1);
    chk("stall_resp", 64'(last_resp(0)), 64'd4);

    // Argument word missing: must wait in ARG
    model(2'b01, 2, 32'h33);
    chq.push_back(cmd_word(2'b01, 2));
    refresh_chan();
    d0 = deq_cnt;
    w0 = wr_total;
    for (int i = 0; i < 10; i++) tick();
    chk("arg_wait_one_deq", 64'(deq_cnt - d0), 64'd1);
    chk("arg_wait_busy", 64'(s_busy), 64'd1);
    chk("arg_wait_no_write", 64'(wr_total - w0), 64'd0);
    chq.push_back(32'h33);
    refresh_chan();
    wait_done(50);
    chk("arg_wait_resp", 64'(last_resp(0)), 64'd2);

    // Reset at RUN index 7 of FILL 32
    issue(2'b01, 32, 32'h0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(s_we && s_addr == 12'd6) && n < 60);
    chk("rst_reach_idx6", 64'(s_addr), 64'd6);
    rst = 1'b1;
    tick();
    exp_wa.delete();
    exp_wd.delete();
    exp_resp.delete();
    rst = 1'b0;
    e0 = enq_cnt;
    tick();
    chk("abort_flags", {60'h0, s_deq, s_enq, s_we, s_busy}, 64'h0);
    chk("abort_comm_d", 64'(s_d), 64'h0);
    chk("abort_mem_addr", 64'(s_addr), 64'h0);
    chk("abort_mem_d", 64'(s_md), 64'h0);
    for (int i = 0; i < 10; i++) tick();
    chk("abort_no_resp", 64'(enq_cnt - e0), 64'd0);
    chk("abort_ram8_untouched", 64'(ram[8]), 64'hA000_0008);

    // Recovery after abort
    issue(2'b01, 4, 32'h40);
    wait_done(50);
    chk("recover_resp", 64'(last_resp(0)), 64'd4);
    chk("recover_ram3", 64'(ram[3]), 64'h43);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/microbench_seq_ctrl.md
# microbench_seq_ctrl

Command-driven sequencer for one CoramMemory1P in the microbenchmark designs. It takes a two-word command from the control thread over the CoramChannel and runs a timed fill or verify pass over the memory, one word per cycle. It then enqueues the measured cycle count, plus the mismatch count for verify, back to the thread. It sits between the user-logic ports of the channel and the memory and replaces ad-hoc per-benchmark state machines.

## Interface
- SIMD_WIDTH, 1, lanes per memory word
- W_D, 32, bits per lane
- W_A, 12, memory address width
- W_COMM_D, 32, channel data width (≥ W_A+3)
- CLK  in  1  clock
- RST  in  1  reset; one clock, synchronous, active-high
- comm_q  in  W_COMM_D  channel head word, valid while comm_empty=0
- comm_empty  in  1  channel empty
- comm_deq  out  1  pop pulse
- comm_d  out  W_COMM_D  response word
- comm_enq  out  1  push pulse
- comm_full  in  1  channel full
- mem_addr  out  W_A  memory address
- mem_d  out  W_D*SIMD_WIDTH  write data
- mem_we  out  1  write enable
- mem_q  in  W_D*SIMD_WIDTH  read data, 1-cycle latency after mem_addr
- busy  out  1  high in every state except IDLE

## Operation
- Command word: bits [W_COMM_D-1:W_COMM_D-2] give opcode: 01=FILL, 10=VERIFY, 00/11=illegal. Bits [W_A:0] give LEN, 0..2^W_A. Other bits are ignored.
- Argument word: SEED[W_D-1:0]. The expected/written pattern for index i is every lane = (SEED+i) mod 2^W_D.
- States:
  - IDLE: if !comm_empty, pulse comm_deq, latch the command, go to CWAIT.
  - CWAIT: one cycle, because the empty flag updates late. Illegal opcode → ERR. Otherwise → ARG.
  - ARG: if !comm_empty, pulse comm_deq, latch SEED, clear counters, go to AWAIT.
  - AWAIT: one cycle. LEN=0 → RESP0. Otherwise → RUN.
  - RUN: issue index i=0..LEN-1, one per cycle.
    - FILL: mem_we=1, mem_d=pattern(i).
    - VERIFY: mem_we=0.
    - After the last index: FILL → RESP0, VERIFY → DRAIN.
  - DRAIN: one cycle to compare the last read, then → RESP0.
  - RESP0: when !comm_full, enq cycles. FILL → IDLE, VERIFY → RESP1.
  - RESP1: when !comm_full, enq mismatches, → IDLE.
  - ERR: when !comm_full, enq all-ones, → IDLE. The argument word is not consumed.
- Compare rule: in the cycle after index i is issued, the whole mem_q word is compared with pattern(i). A mismatch in any lane counts as one mismatch.
- cycles: incremented once per RUN and DRAIN cycle. FILL reports LEN, VERIFY reports LEN+1, LEN=0 reports 0.
- Both counters are 32-bit, saturate at all-ones, and are zero-extended or truncated to W_COMM_D.
- Address wrap: LEN=2^W_A covers every address once. mem_addr wraps to 0 after the pass. No index beyond LEN-1 is issued.
- Responses wait indefinitely while comm_full=1. comm_enq is never asserted while comm_full=1.
- comm_deq is never asserted while comm_empty=1. A new command is never accepted before all responses are enqueued.

## Timing
- All outputs are registered. Reset values: comm_deq=0, comm_enq=0, comm_d=0, mem_addr=0, mem_d=0, mem_we=0, busy=0. State returns to IDLE.
- RST mid-pass aborts immediately: no further memory writes and no response. Counters clear. Words already popped are lost.
- Earliest first memory access: 4 cycles after comm_empty first reads 0 in IDLE, assuming both words are present.
- Fill pass: the write for index i is presented in RUN cycle i. The response is enqueued in the cycle after the last write if the channel is not full.
- mem_we is 0 in every state other than RUN(FILL).

## Structure
- Shared package microbench_pkg holds:
  - opcode constants OP_FILL/OP_VERIFY
  - the state encoding localparams
  - RESP_ERR (all-ones)
  - the counter width (32)
- One sub-module, microbench_sat_counter: a width parameter plus clear and inc inputs, saturating. It is instantiated twice, for cycles and mismatches.
- Pattern generation and lane replication stay inline.

## Test plan
- FILL LEN=16, SEED=0x100 → mem[0..15]=0x100..0x10F on all lanes; one response word = 16; mem_we low afterward.
- VERIFY LEN=16, SEED=0x100 with the bench RAM model preloaded correctly → responses 17, 0. Corrupt mem[5] and mem[15] in one lane → 17, 2.
- LEN=0 FILL → no mem_we pulse, response 0. Opcode 11 → single response 0xFFFFFFFF, argument word left in the channel and accepted as the next command.
- LEN=2^W_A FILL → 4096 writes covering addresses 0..4095 exactly once, response 4096.
- comm_full held high for 10 cycles at RESP0 → no comm_enq during the stall; exactly one enq after release. Empty channel between the command and argument words → block waits in ARG with comm_deq low.
- RST asserted at RUN index 7 of a FILL LEN=32 → all outputs 0 next cycle, no response. A subsequent FILL LEN=4 completes with response 4.
